// File: rtl/oam_write_port.sv
// 256-byte sprite OAM with OAMADDR ($2003), OAMDATA ($2004) write/read and a sprite-evaluation read port.
// Optional build macro OAM_ATTR_MASK_EN clears bits [4:2] of attribute bytes (addr[1:0] == 2'b10) on store.
module oam_write_port #(
  parameter int unsigned OAM_BYTES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       stop,
  input  logic       reg_wr,
  input  logic       reg_rd,
  input  logic       reg_sel,
  input  logic [7:0] cpu_wdata,
  input  logic       dma_write,
  input  logic [7:0] dma_wdata,
  input  logic       rendering,
  input  logic       addr_clear,
  input  logic [7:0] eval_addr,
  output logic [7:0] eval_rdata,
  output logic [7:0] cpu_rdata,
  output logic [7:0] oam_addr
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic [DW-1:0] mem_q [OAM_BYTES];
  logic [AW-1:0] oam_addr_q, oam_addr_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] eval_rdata_q, eval_rdata_d;

  logic          upd;
  logic          wr_any;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] store_data;
  logic          store_en;

  always_comb begin
    upd      = ~stop & cpu_en;
    wr_any   = dma_write | (reg_wr & reg_sel);
    wr_data  = dma_write ? dma_wdata : cpu_wdata;
    store_en = upd & wr_any & ~rendering & ~reset;
`ifdef OAM_ATTR_MASK_EN
    store_data = (oam_addr_q[1:0] == 2'b10) ? (wr_data & 8'hE3) : wr_data;
`else
    store_data = wr_data;
`endif
  end

  // OAMADDR next state: clear beats a $2003 write, which DMA in turn overrides.
  always_comb begin
    oam_addr_d   = oam_addr_q;
    cpu_rdata_d  = cpu_rdata_q;
    eval_rdata_d = eval_rdata_q;
    if (upd) begin
      if (addr_clear) begin
        oam_addr_d = '0;
      end else if (reg_wr & ~reg_sel & ~dma_write) begin
        oam_addr_d = cpu_wdata;
      end else if (wr_any & ~rendering) begin
        oam_addr_d = AW'(oam_addr_q + 8'd1);
      end else if (wr_any) begin
        // Rendering-time write glitch: only the sprite index advances.
        oam_addr_d = {6'(oam_addr_q[7:2] + 6'd1), oam_addr_q[1:0]};
      end
      if (reg_rd & reg_sel) begin
        cpu_rdata_d = mem_q[oam_addr_q];
      end
    end
    if (~stop) begin
      eval_rdata_d = mem_q[eval_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      oam_addr_q   <= '0;
      cpu_rdata_q  <= '0;
      eval_rdata_q <= '0;
    end else begin
      oam_addr_q   <= oam_addr_d;
      cpu_rdata_q  <= cpu_rdata_d;
      eval_rdata_q <= eval_rdata_d;
    end
  end

  // Storage is deliberately not reset; contents survive a PPU reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      mem_q[oam_addr_q] <= store_data;
    end
  end

  assign oam_addr   = oam_addr_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign eval_rdata = eval_rdata_q;

endmodule

// File: tb/tb_oam_write_port.sv
// Directed table-driven bench for oam_write_port, plus DMA-stream and reset-mid-DMA sequences.
module tb_oam_write_port;

`ifdef OAM_ATTR_MASK_EN
  localparam logic [7:0] ATTR_FF = 8'hE3;
`else
  localparam logic [7:0] ATTR_FF = 8'hFF;
`endif

  logic       clk = 1'b0;
  logic       reset, cpu_en, stop, reg_wr, reg_rd, reg_sel;
  logic [7:0] cpu_wdata, dma_wdata, eval_addr;
  logic       dma_write, rendering, addr_clear;
  logic [7:0] eval_rdata, cpu_rdata, oam_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  oam_write_port dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_en     (cpu_en),
    .stop       (stop),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_sel    (reg_sel),
    .cpu_wdata  (cpu_wdata),
    .dma_write  (dma_write),
    .dma_wdata  (dma_wdata),
    .rendering  (rendering),
    .addr_clear (addr_clear),
    .eval_addr  (eval_addr),
    .eval_rdata (eval_rdata),
    .cpu_rdata  (cpu_rdata),
    .oam_addr   (oam_addr)
  );

  typedef struct {
    logic       wr, rd, sel;
    logic [7:0] wd;
    logic       dw;
    logic [7:0] dd;
    logic       rend, clr, en, stp;
    logic [7:0] ea;
    logic [7:0] exp_addr;
    logic       chk_rd;
    logic [7:0] exp_rd;
    logic       chk_ev;
    logic [7:0] exp_ev;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic rd, input logic sel, input logic [7:0] wd,
                              input logic dw, input logic [7:0] dd, input logic rend, input logic clr,
                              input logic en, input logic stp, input logic [7:0] ea,
                              input logic [7:0] exp_addr, input logic chk_rd, input logic [7:0] exp_rd,
                              input logic chk_ev, input logic [7:0] exp_ev);
    vec_t v;
    v.wr = wr; v.rd = rd; v.sel = sel; v.wd = wd; v.dw = dw; v.dd = dd;
    v.rend = rend; v.clr = clr; v.en = en; v.stp = stp; v.ea = ea;
    v.exp_addr = exp_addr; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    v.chk_ev = chk_ev; v.exp_ev = exp_ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; cpu_en = 1'b1; stop = 1'b0;
    reg_wr = 1'b0; reg_rd = 1'b0; reg_sel = 1'b0; cpu_wdata = 8'h00;
    dma_write = 1'b0; dma_wdata = 8'h00; rendering = 1'b0; addr_clear = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [7:0] a);
    idle(); reg_wr = 1'b1; cpu_wdata = a;
    tick();
    idle();
  endtask

  task automatic dma_byte(input logic [7:0] d);
    idle(); dma_write = 1'b1; dma_wdata = d;
    tick();
    idle();
  endtask

  task automatic eval_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    idle(); eval_addr = a;
    tick();
    chk(name, eval_rdata, exp);
  endtask

  initial begin
    //           wr  rd  sel wd     dw  dd     rnd clr en  stp ea     addr   crd rd     cev ev
    vecs.push_back(mk(1, 0, 0, 8'h10, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h10, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 8'hAA, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h11, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 8'hBB, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h12, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h10, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h10, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h10, 1, 8'hAA, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h11, 8'h10, 1, 8'hAA, 1, 8'hBB));
    vecs.push_back(mk(1, 1, 1, 8'hCC, 0, 8'h00, 0, 0, 1, 0, 8'h10, 8'h11, 1, 8'hAA, 1, 8'hAA));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h10, 8'h11, 0, 8'h00, 1, 8'hCC));
    vecs.push_back(mk(1, 0, 0, 8'h05, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h05, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 8'h5A, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h06, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h05, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h05, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 8'h77, 0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h09, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h05, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h05, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h05, 1, 8'h5A, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'hFD, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'hFD, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 8'h77, 0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h01, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h20, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h20, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h40, 0, 8'h00, 0, 1, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h20, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h20, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 8'h3C, 0, 8'h00, 0, 1, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h20, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h20, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h20, 1, 8'h3C, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 8'h99, 0, 8'h00, 0, 0, 0, 0, 8'h20, 8'h20, 0, 8'h00, 1, 8'h3C));
    vecs.push_back(mk(1, 1, 1, 8'h99, 0, 8'h00, 0, 0, 1, 1, 8'h10, 8'h20, 1, 8'h3C, 1, 8'h3C));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h20, 1, 8'h3C, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h30, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h30, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 8'h22, 1, 8'h11, 0, 0, 1, 0, 8'h00, 8'h31, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h30, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h30, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h30, 1, 8'h11, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h50, 1, 8'h66, 0, 0, 1, 0, 8'h00, 8'h31, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h30, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h30, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h30, 1, 8'h66, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h02, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h02, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 8'hFF, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h03, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 8'hFF, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h04, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 8'h02, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h02, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h03, 8'h02, 1, ATTR_FF, 1, 8'hFF));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h02, 8'h02, 0, 8'h00, 1, ATTR_FF));
    vecs.push_back(mk(1, 0, 0, 8'hFF, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 8'h12, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00));

    idle();
    eval_addr = 8'h00;
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_oam_addr", oam_addr, 8'h00);
    chk("reset_cpu_rdata", cpu_rdata, 8'h00);
    chk("reset_eval_rdata", eval_rdata, 8'h00);
    idle();

    for (int i = 0; i < vecs.size(); i++) begin
      reg_wr = vecs[i].wr; reg_rd = vecs[i].rd; reg_sel = vecs[i].sel; cpu_wdata = vecs[i].wd;
      dma_write = vecs[i].dw; dma_wdata = vecs[i].dd; rendering = vecs[i].rend;
      addr_clear = vecs[i].clr; cpu_en = vecs[i].en; stop = vecs[i].stp; eval_addr = vecs[i].ea;
      tick();
      chk($sformatf("vec%0d_oam_addr", i), oam_addr, vecs[i].exp_addr);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vecs[i].exp_rd);
      if (vecs[i].chk_ev) chk($sformatf("vec%0d_eval_rdata", i), eval_rdata, vecs[i].exp_ev);
    end
    idle();

    // Full 256-byte DMA starting mid-page wraps and leaves OAMADDR where it began.
    set_addr(8'hFE);
    for (int i = 0; i < 256; i++) dma_byte(8'(i));
    chk("dma_end_oam_addr", oam_addr, 8'hFE);
    eval_chk("dma_mem_fe", 8'hFE, 8'h00);
    eval_chk("dma_mem_00", 8'h00, 8'h02);
    eval_chk("dma_mem_fd", 8'hFD, 8'hFF);

    // Reset in the middle of a DMA stream.
    set_addr(8'h80);
    dma_byte(8'hA0);
    dma_byte(8'hA1);
    dma_byte(8'hA2);
    chk("middma_oam_addr", oam_addr, 8'h83);
    idle(); reset = 1'b1;
    tick();
    chk("middma_reset_addr", oam_addr, 8'h00);
    chk("middma_reset_eval", eval_rdata, 8'h00);
    idle();
    dma_byte(8'hB0);
    chk("postreset_oam_addr", oam_addr, 8'h01);
    eval_chk("postreset_mem_81", 8'h81, 8'hA1);
    eval_chk("postreset_mem_00", 8'h00, 8'hB0);
    eval_chk("postreset_mem_82", 8'h82, 8'hA2);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
